ahb_burst_master: RTL and testbench

AHB_BURST_MASTER -- requirements
Module: ahb_burst_master

---
 rtl/ahb_burst_master.sv | 178 +++++++++++++++++
 tb/tb_ahb_burst_master.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: turns one command into a SINGLE/INCRx transfer sequence on the bus.
// Latency: first address phase the cycle after cmd accept; done/err strobe with the final bus response.
// Backpressure: Hready_out low freezes address/control and Hwdata; cmd_ready is high only in IDLE.
module ahb_burst_master #(
    parameter int         DATA_W    = 32,
    parameter int         ADDR_W    = 32,
    parameter int         MAX_BEATS = 16,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic                           Hclk,
    input  logic                           Hresetn,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic                           cmd_write,
    input  logic [ADDR_W-1:0]              cmd_addr,
    input  logic [$clog2(MAX_BEATS+1)-1:0] cmd_beats,
    input  logic [2:0]                     cmd_size,
    input  logic [DATA_W-1:0]              wr_data,
    output logic                           wr_pop,
    output logic [DATA_W-1:0]              rd_data,
    output logic                           rd_valid,
    output logic                           done,
    output logic                           err,
    output logic [ADDR_W-1:0]              Haddr,
    output logic [1:0]                     Htrans,
    output logic                           Hwrite,
    output logic [2:0]                     Hsize,
    output logic [2:0]                     Hburst,
    output logic [3:0]                     Hprot,
    output logic [DATA_W-1:0]              Hwdata,
    input  logic                           Hready_out,
    input  logic                           Hresp,
    input  logic [DATA_W-1:0]              Hrdata
);

    localparam int BEAT_W   = $clog2(MAX_BEATS + 1);
    localparam int MAX_SIZE = $clog2(DATA_W / 8);

    typedef enum logic [2:0] {IDLE, NSEQ, SEQ, LAST, ERR2} state_t;

    // Address-phase control held for the whole burst.
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [2:0]        size;
        logic [2:0]        burst;
    } ctl_t;

    state_t            state_q, state_d;
    ctl_t              ctl_q;
    logic [BEAT_W-1:0] rem_q;      // address beats still to issue after the one on the bus
    logic              cross_q;    // beat on the bus restarts the burst after a 1 KB crossing
    logic [DATA_W-1:0] hwdata_q;
    logic [3:0]        hprot_q;
    logic              live_q;     // first clock after reset release has been seen

    logic [BEAT_W-1:0] cmd_n;
    logic [2:0]        cmd_sz;
    logic [2:0]        cmd_burst;
    logic [ADDR_W-1:0] next_addr;
    logic              next_cross;
    logic              addr_beat;
    logic              dphase;
    logic              accept;
    logic              cmd_take;

    // A zero beat count means one beat; oversized transfers clamp to the bus width.
    assign cmd_n  = (cmd_beats == '0) ? BEAT_W'(1) : cmd_beats;
    assign cmd_sz = (cmd_size > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : cmd_size;

    // Burst encoding from the beat count; undefined lengths use INCR.
    always_comb begin
        cmd_burst = 3'b001;
        case (int'(cmd_n))
            1:       cmd_burst = 3'b000;
            4:       cmd_burst = 3'b011;
            8:       cmd_burst = 3'b101;
            16:      cmd_burst = 3'b111;
            default: cmd_burst = 3'b001;
        endcase
    end

    assign next_addr  = ctl_q.addr + (ADDR_W'(1) << ctl_q.size);
    assign next_cross = next_addr[ADDR_W-1:10] != ctl_q.addr[ADDR_W-1:10];
    assign addr_beat  = (state_q == NSEQ) || (state_q == SEQ);
    assign dphase     = (state_q == SEQ) || (state_q == LAST);
    assign accept     = addr_beat && Hready_out && !Hresp;
    assign cmd_take   = cmd_valid && cmd_ready;

    // State register.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state: step on accepted beats, divert to ERR2 on the first ERROR cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (cmd_take) state_d = NSEQ;
            NSEQ: if (Hready_out) state_d = (rem_q == '0) ? LAST : SEQ;
            SEQ: begin
                if (Hresp)                             state_d = Hready_out ? IDLE : ERR2;
                else if (Hready_out && rem_q == '0)    state_d = LAST;
            end
            LAST: begin
                if (Hresp)           state_d = Hready_out ? IDLE : ERR2;
                else if (Hready_out) state_d = IDLE;
            end
            ERR2: if (Hready_out) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address/control register: loads on command accept, steps on each accepted non-final beat.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            ctl_q   <= '0;
            rem_q   <= '0;
            cross_q <= 1'b0;
        end else if (cmd_take) begin
            ctl_q.write <= cmd_write;
            ctl_q.addr  <= cmd_addr;
            ctl_q.size  <= cmd_sz;
            ctl_q.burst <= cmd_burst;
            rem_q       <= cmd_n - BEAT_W'(1);
            cross_q     <= 1'b0;
        end else if (accept && (rem_q != '0)) begin
            ctl_q.addr <= next_addr;
            if (next_cross) ctl_q.burst <= 3'b001;
            rem_q      <= rem_q - BEAT_W'(1);
            cross_q    <= next_cross;
        end
    end

    // Write data follows its address beat into the data phase and holds through waits.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn)                  hwdata_q <= '0;
        else if (accept && ctl_q.write) hwdata_q <= wr_data;
    end

    // Hprot and cmd_ready stay low in reset and come up on the first clock after release.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            hprot_q <= 4'b0000;
            live_q  <= 1'b0;
        end else begin
            hprot_q <= HPROT_VAL;
            live_q  <= 1'b1;
        end
    end

    // Transfer type decoded from state; a post-crossing beat restarts as NONSEQ.
    always_comb begin
        Htrans = 2'b00;
        case (state_q)
            NSEQ:    Htrans = 2'b10;
            SEQ:     Htrans = cross_q ? 2'b10 : 2'b11;
            default: Htrans = 2'b00;
        endcase
    end

    assign Haddr     = ctl_q.addr;
    assign Hwrite    = ctl_q.write;
    assign Hsize     = ctl_q.size;
    assign Hburst    = ctl_q.burst;
    assign Hprot     = hprot_q;
    assign Hwdata    = hwdata_q;
    assign cmd_ready = (state_q == IDLE) && live_q;

    // Strobes are state decodes qualified by the slave handshake of the current cycle.
    assign wr_pop   = accept && ctl_q.write;
    assign rd_valid = dphase && !ctl_q.write && Hready_out && !Hresp;
    assign rd_data  = rd_valid ? Hrdata : '0;
    assign done     = (state_q == LAST) && Hready_out && !Hresp;
    assign err      = Hready_out && ((state_q == ERR2) || (dphase && Hresp));

endmodule

// File: tb/tb_ahb_burst_master.sv
`timescale 1ns/1ps
module tb_ahb_burst_master;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int MAX_BEATS = 16;
    localparam int BW        = $clog2(MAX_BEATS + 1);
    localparam int OUT_W     = 3 * DATA_W + ADDR_W + 18;

    logic              Hclk;
    logic              Hresetn;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [BW-1:0]     cmd_beats;
    logic [2:0]        cmd_size;
    logic [DATA_W-1:0] wr_data;
    logic              wr_pop;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] Haddr;
    logic [1:0]        Htrans;
    logic              Hwrite;
    logic [2:0]        Hsize;
    logic [2:0]        Hburst;
    logic [3:0]        Hprot;
    logic [DATA_W-1:0] Hwdata;
    logic              Hready_out;
    logic              Hresp;
    logic [DATA_W-1:0] Hrdata;

    logic [OUT_W-1:0]  all_outs;
    int total = 0;
    int bad   = 0;

    ahb_burst_master #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BEATS(MAX_BEATS), .HPROT_VAL(4'b0011)
    ) dut (
        .Hclk(Hclk), .Hresetn(Hresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_beats(cmd_beats), .cmd_size(cmd_size),
        .wr_data(wr_data), .wr_pop(wr_pop), .rd_data(rd_data), .rd_valid(rd_valid),
        .done(done), .err(err),
        .Haddr(Haddr), .Htrans(Htrans), .Hwrite(Hwrite), .Hsize(Hsize), .Hburst(Hburst),
        .Hprot(Hprot), .Hwdata(Hwdata),
        .Hready_out(Hready_out), .Hresp(Hresp), .Hrdata(Hrdata)
    );

    assign all_outs = {cmd_ready, wr_pop, rd_data, rd_valid, done, err, Haddr, Htrans,
                       Hwrite, Hsize, Hburst, Hprot, Hwdata};

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    // Burst type the bus should carry for an n-beat command.
    function automatic logic [2:0] burst_code(input int n);
        case (n)
            1:       return 3'b000;
            4:       return 3'b011;
            8:       return 3'b101;
            16:      return 3'b111;
            default: return 3'b001;
        endcase
    endfunction

    // Issues one command and plays the slave. The expected beat list is built up front
    // from the addressing rules; each cycle the bus and strobes are compared against it.
    // done_cyc returns cycles from the command handshake to done (-1 if none).
    task automatic run_burst(input bit wr, input logic [31:0] addr, input int beats,
                             input int size, input int wait_pct, input int wait_beat,
                             input int err_beat, input int abort_beat, input bit junk,
                             output int done_cyc);
        logic [31:0]       ea[$];
        logic [1:0]        et[$];
        logic [2:0]        eb[$];
        logic [DATA_W-1:0] wd[$];
        logic [DATA_W-1:0] rq[$];
        logic [31:0]       a, prev;
        logic [1:0]        exp_tr;
        int  nb, sz, issued, dp_idx, err_st, cyc;
        bit  crossed, cr, dp_valid, fin, waited, busy, rdy, rsp;
        bit  e_pop, e_rv, e_done, e_err;

        nb = (beats == 0) ? 1 : beats;
        sz = (size > 2) ? 2 : size;
        crossed = 1'b0;
        prev = addr;
        for (int k = 0; k < nb; k++) begin
            a  = addr + 32'(k << sz);
            cr = (k > 0) && ((a >> 10) != (prev >> 10));
            if (cr) crossed = 1'b1;
            ea.push_back(a);
            et.push_back((k == 0 || cr) ? 2'b10 : 2'b11);
            eb.push_back(crossed ? 3'b001 : burst_code(nb));
            wd.push_back(DATA_W'($urandom));
            rq.push_back(DATA_W'($urandom));
            prev = a;
        end

        done_cyc = -1;
        @(negedge Hclk);
        cmd_write  = wr;
        cmd_addr   = addr;
        cmd_beats  = BW'(beats);
        cmd_size   = 3'(size);
        cmd_valid  = 1'b1;
        wr_data    = wd[0];
        Hready_out = 1'b1;
        Hresp      = 1'b0;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL cmd_ready_idle got=%b exp=1", cmd_ready);
        end

        issued = 0; dp_idx = 0; err_st = 0; cyc = 0;
        dp_valid = 1'b0; fin = 1'b0; waited = 1'b0;
        while (!fin) begin
            @(negedge Hclk);
            if (issued == abort_beat) return;
            cmd_valid = junk && (issued < nb);
            if (junk) begin
                cmd_addr  = $urandom;
                cmd_beats = BW'($urandom_range(MAX_BEATS));
                cmd_write = ~wr;
                cmd_size  = 3'($urandom_range(7));
            end
            busy   = (err_st == 0) && (issued < nb);
            exp_tr = busy ? et[issued] : 2'b00;
            total++;
            if (Htrans !== exp_tr) begin
                bad++;
                $display("FAIL htrans beat=%0d got=%b exp=%b", issued, Htrans, exp_tr);
            end
            if (busy) begin
                total++;
                if (Haddr !== ea[issued]) begin
                    bad++;
                    $display("FAIL haddr beat=%0d got=%h exp=%h", issued, Haddr, ea[issued]);
                end
                total++;
                if (Hburst !== eb[issued]) begin
                    bad++;
                    $display("FAIL hburst beat=%0d got=%b exp=%b", issued, Hburst, eb[issued]);
                end
                total++;
                if ({Hsize, Hwrite, Hprot} !== {3'(sz), wr, 4'b0011}) begin
                    bad++;
                    $display("FAIL ctrl size/write/prot got=%h exp=%h", {Hsize, Hwrite, Hprot},
                             {3'(sz), wr, 4'b0011});
                end
            end
            total++;
            if (cmd_ready !== 1'b0) begin
                bad++;
                $display("FAIL cmd_ready_busy got=%b exp=0", cmd_ready);
            end
            if (dp_valid && wr) begin
                total++;
                if (Hwdata !== wd[dp_idx]) begin
                    bad++;
                    $display("FAIL hwdata beat=%0d got=%h exp=%h", dp_idx, Hwdata, wd[dp_idx]);
                end
            end

            // Slave response for the data phase in progress.
            rsp = 1'b0;
            rdy = 1'b1;
            if (err_st == 1) begin
                rsp = 1'b1;
            end else if (dp_valid && dp_idx == err_beat) begin
                rdy = 1'b0; rsp = 1'b1;
            end else if (dp_valid && dp_idx == wait_beat && !waited) begin
                rdy = 1'b0; waited = 1'b1;
            end else if (dp_valid && $urandom_range(99) < wait_pct) begin
                rdy = 1'b0;
            end
            Hready_out = rdy;
            Hresp      = rsp;
            Hrdata     = dp_valid ? rq[dp_idx] : DATA_W'($urandom);
            wr_data    = (issued < nb) ? wd[issued] : DATA_W'($urandom);
            #1;

            e_pop  = rdy && !rsp && busy && wr;
            e_rv   = rdy && !rsp && dp_valid && !wr;
            e_done = rdy && !rsp && dp_valid && !busy && (err_st == 0);
            e_err  = rdy && (err_st == 1);
            total++;
            if ({wr_pop, rd_valid, done, err} !== {e_pop, e_rv, e_done, e_err}) begin
                bad++;
                $display("FAIL strobes pop/rv/done/err cyc=%0d got=%b exp=%b", cyc,
                         {wr_pop, rd_valid, done, err}, {e_pop, e_rv, e_done, e_err});
            end
            if (e_rv) begin
                total++;
                if (rd_data !== rq[dp_idx]) begin
                    bad++;
                    $display("FAIL rd_data beat=%0d got=%h exp=%h", dp_idx, rd_data, rq[dp_idx]);
                end
            end

            if (err_st == 1) begin
                fin = 1'b1;
            end else if (rsp && !rdy) begin
                err_st = 1;
            end else if (rdy) begin
                if (busy) begin
                    dp_valid = 1'b1; dp_idx = issued; issued++;
                end else if (dp_valid) begin
                    dp_valid = 1'b0; fin = 1'b1; done_cyc = cyc + 1;
                end
            end
            cyc++;
            if (cyc > 300 && !fin) begin
                total++; bad++;
                $display("FAIL burst_timeout cycles=%0d exp<=300", cyc);
                fin = 1'b1;
            end
        end

        @(negedge Hclk);
        cmd_valid  = 1'b0;
        Hready_out = 1'b1;
        Hresp      = 1'b0;
        total++;
        if ({cmd_ready, Htrans, done, err} !== 5'b10000) begin
            bad++;
            $display("FAIL back_to_idle ready/trans/done/err got=%b exp=10000",
                     {cmd_ready, Htrans, done, err});
        end
    endtask

    task automatic test_reset();
        Hresetn    = 1'b0;
        cmd_valid  = 1'b1;
        cmd_write  = 1'b1;
        cmd_addr   = 32'hDEAD_BEEF;
        cmd_beats  = BW'(4);
        cmd_size   = 3'd2;
        wr_data    = 32'h1234_5678;
        Hready_out = 1'b1;
        Hresp      = 1'b0;
        Hrdata     = 32'hA5A5_A5A5;
        repeat (3) @(negedge Hclk);
        total++;
        if (all_outs !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0", all_outs);
        end
        cmd_valid = 1'b0;
        Hresetn   = 1'b1;
        #1;
        total++;
        if (cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_at_release got=%b exp=0", cmd_ready);
        end
        @(negedge Hclk);
        total++;
        if ({cmd_ready, Htrans, Hprot} !== {1'b1, 2'b00, 4'b0011}) begin
            bad++;
            $display("FAIL ready_after_release got=%b exp=1000011", {cmd_ready, Htrans, Hprot});
        end
    endtask

    task automatic test_single_write();
        int dc;
        run_burst(1'b1, 32'h100, 1, 2, 0, -1, -1, -1, 1'b0, dc);
        total++;
        if (dc !== 2) begin
            bad++;
            $display("FAIL single_done_latency got=%0d exp=2", dc);
        end
    endtask

    task automatic test_incr4_read_wait();
        int dc;
        run_burst(1'b0, 32'h40, 4, 2, 0, 1, -1, -1, 1'b0, dc);
        total++;
        if (dc !== 6) begin
            bad++;
            $display("FAIL incr4_done_latency got=%0d exp=6", dc);
        end
    endtask

    task automatic test_kb_cross();
        int dc;
        run_burst(1'b1, 32'h3F8, 5, 2, 0, -1, -1, -1, 1'b0, dc);
        run_burst(1'b0, 32'h3F0, 16, 2, 30, -1, -1, -1, 1'b0, dc);
        total++;
        if (dc < 17) begin
            bad++;
            $display("FAIL incr16_cross_latency got=%0d exp>=17", dc);
        end
    endtask

    task automatic test_error_write();
        int dc;
        run_burst(1'b1, 32'h200, 8, 2, 0, -1, 1, -1, 1'b0, dc);
        total++;
        if (dc !== -1) begin
            bad++;
            $display("FAIL error_no_done got=%0d exp=-1", dc);
        end
    endtask

    task automatic test_reset_mid_burst();
        int dc;
        run_burst(1'b1, 32'h800, 16, 2, 20, -1, -1, 2, 1'b0, dc);
        Hresetn = 1'b0;
        #1;
        total++;
        if (all_outs !== '0) begin
            bad++;
            $display("FAIL midburst_reset_outputs got=%h exp=0", all_outs);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge Hclk);
            total++;
            if ({done, err, Htrans} !== 4'b0000) begin
                bad++;
                $display("FAIL reset_hold done/err/trans got=%b exp=0000", {done, err, Htrans});
            end
        end
        Hresetn = 1'b1;
        #1;
        total++;
        if (cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_at_release2 got=%b exp=0", cmd_ready);
        end
        run_burst(1'b0, 32'h1000, 4, 2, 0, -1, -1, -1, 1'b0, dc);
        total++;
        if (dc !== 5) begin
            bad++;
            $display("FAIL fresh_cmd_latency got=%0d exp=5", dc);
        end
    endtask

    task automatic test_back_to_back();
        int dc;
        run_burst(1'b1, 32'h2000, 4, 1, 0, -1, -1, -1, 1'b1, dc);
        run_burst(1'b0, 32'h3000, 8, 0, 0, -1, -1, -1, 1'b1, dc);
        run_burst(1'b1, 32'h4000, 0, 5, 0, -1, -1, -1, 1'b1, dc);
        total++;
        if (dc !== 2) begin
            bad++;
            $display("FAIL zero_beats_latency got=%0d exp=2", dc);
        end
    endtask

    task automatic test_random();
        int dc;
        for (int i = 0; i < 30; i++) begin
            bit          wr;
            logic [31:0] a;
            int          b, s, e, n;
            wr = 1'($urandom);
            s  = $urandom_range(7);
            b  = $urandom_range(MAX_BEATS);
            n  = (b == 0) ? 1 : b;
            a  = $urandom;
            if (i % 2 == 0) a[9:0] = 10'h3C0 + 10'($urandom_range(63));
            a  = a & ~((32'd1 << ((s > 2) ? 2 : s)) - 32'd1);
            e  = ($urandom_range(4) == 0) ? int'($urandom_range(n - 1)) : -1;
            run_burst(wr, a, b, s, 25, -1, e, -1, 1'($urandom), dc);
            total++;
            if ((e < 0 && dc < n + 1) || (e >= 0 && dc != -1)) begin
                bad++;
                $display("FAIL random_completion cmd=%0d got=%0d exp=%s", i, dc,
                         (e < 0) ? "done" : "no_done");
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_incr4_read_wait();
        test_kb_cross();
        test_error_write();
        test_reset_mid_burst();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
